// File: rtl/dekatron_counter_if.sv
// rtl/dekatron_counter_if.sv - control/status bundle between the dekatron counter and its driver
interface dekatron_counter_if #(
  parameter int DIGITS = 3
);
  logic                   Set;
  logic [DIGITS*4-1:0]    In;
  logic                   Request;
  logic                   Dec;
  logic                   Ready;
  logic [DIGITS*10-1:0]   Out;
  logic                   Zero;
  logic                   Carry;

  modport master (
    output Set, In, Request, Dec,
    input  Ready, Out, Zero, Carry
  );

  modport slave (
    input  Set, In, Request, Dec,
    output Ready, Out, Zero, Carry
  );
endinterface

// File: rtl/dekatron_counter.sv
// rtl/dekatron_counter.sv - multi-digit one-hot decade ring counter with serial carry/borrow ripple
module dekatron_counter #(
  parameter int DIGITS      = 3,
  parameter int STEP_CYCLES = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  dekatron_counter_if.slave  bus
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] TOP_IDX    = IW'(DIGITS - 1);

  typedef enum logic {IDLE, STEP} state_t;

  state_t          state;
  logic [9:0]      glow [DIGITS];
  logic [TW-1:0]   timer;
  logic [IW-1:0]   idx;
  logic            dec_q;
  logic            ready_q;
  logic            carry_q;

  logic [9:0]      cur;
  logic [9:0]      nxt;
  logic            wrap;
  logic            zero_c;

  // Out-of-range BCD nibbles park the tube at position 0.
  function automatic logic [9:0] decode_bcd(input logic [3:0] n);
    logic [9:0] oh;
    oh = 10'd1;
    if (n <= 4'd9) oh = 10'd1 << n;
    return oh;
  endfunction

  always_comb begin
    cur  = glow[idx];
    nxt  = dec_q ? {cur[0], cur[9:1]} : {cur[8:0], cur[9]};
    wrap = dec_q ? cur[0] : cur[9];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < DIGITS; k++) glow[k] <= 10'd1;
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      dec_q   <= 1'b0;
      ready_q <= 1'b1;
      carry_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Set) begin
            for (int k = 0; k < DIGITS; k++) glow[k] <= decode_bcd(bus.In[4*k +: 4]);
          end else if (bus.Request) begin
            dec_q   <= bus.Dec;
            idx     <= '0;
            timer   <= TIMER_LOAD;
            ready_q <= 1'b0;
            state   <= STEP;
          end
        end
        STEP: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            glow[idx] <= nxt;
            // A wrapping digit hands the step to its upper neighbour after another full step period.
            if (wrap && idx != TOP_IDX) begin
              idx   <= idx + IW'(1);
              timer <= TIMER_LOAD;
            end else begin
              carry_q <= wrap;
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Out = '0;
    zero_c  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      bus.Out[10*k +: 10] = glow[k];
      zero_c = zero_c & glow[k][0];
    end
  end

  assign bus.Zero  = zero_c;
  assign bus.Ready = ready_q;
  assign bus.Carry = carry_q;

endmodule

// File: tb/tb_dekatron_counter.sv
// tb/tb_dekatron_counter.sv - scoreboard bench for dekatron_counter against a decimal-arithmetic model
module tb_dekatron_counter;

  localparam int DIGITS = 3;
  localparam int SC     = 4;

  logic clk;
  logic rst;

  dekatron_counter_if #(.DIGITS(DIGITS)) bus ();

  dekatron_counter #(.DIGITS(DIGITS), .STEP_CYCLES(SC)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_set;
    int value;
    bit carry;
    int lat;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   model       = 0;

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd_value(input logic [DIGITS*4-1:0] in);
    int v;
    v = 0;
    for (int k = 0; k < DIGITS; k++)
      if (in[4*k +: 4] <= 4'd9) v += int'(in[4*k +: 4]) * pow10(k);
    return v;
  endfunction

  // Decimal view of the glow pattern; -1 if any tube is not exactly one-hot.
  function automatic int decode_out(input logic [DIGITS*10-1:0] o);
    int v;
    logic [9:0] s;
    v = 0;
    for (int k = 0; k < DIGITS; k++) begin
      s = o[10*k +: 10];
      if (!$onehot(s)) return -1;
      for (int n = 0; n < 10; n++) if (s[n]) v += n * pow10(k);
    end
    return v;
  endfunction

  function automatic exp_t step_exp(input int v, input bit dn);
    exp_t e;
    int   r;
    int   maxv;
    maxv = pow10(DIGITS);
    r = 0;
    for (int k = 0; k < DIGITS - 1; k++) begin
      if (((v / pow10(k)) % 10) == (dn ? 0 : 9)) r++;
      else break;
    end
    e.is_set = 1'b0;
    e.value  = dn ? (v + maxv - 1) % maxv : (v + 1) % maxv;
    e.carry  = dn ? (v == 0) : (v == maxv - 1);
    e.lat    = (r + 1) * SC;
    return e;
  endfunction

  // Monitor: observes accepted commands on the interface and retires scoreboard entries.
  bit   busy     = 1'b0;
  bit   pend_set = 1'b0;
  bit   prev_rst = 1'b0;
  int   lat_cnt  = 0;
  exp_t cur_e;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      busy     = 1'b0;
      pend_set = 1'b0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        check("reset_out", decode_out(bus.Out), 0);
        check("reset_ready", int'(bus.Ready), 1);
        check("reset_carry", int'(bus.Carry), 0);
        check("reset_zero", int'(bus.Zero), 1);
        prev_rst = 1'b0;
      end else if (pend_set) begin
        pend_set = 1'b0;
        if (q.size() == 0) begin
          check("set_underflow", 1, 0);
        end else begin
          cur_e = q.pop_front();
          check("set_out", decode_out(bus.Out), cur_e.value);
          check("set_zero", int'(bus.Zero), int'(cur_e.value == 0));
          check("set_ready", int'(bus.Ready), 1);
          check("set_carry", int'(bus.Carry), 0);
        end
      end else if (busy) begin
        if (!bus.Ready) begin
          lat_cnt++;
          check("busy_carry", int'(bus.Carry), 0);
          if (lat_cnt > 500) begin
            check("busy_timeout", lat_cnt, 0);
            busy = 1'b0;
          end
        end else begin
          busy = 1'b0;
          if (q.size() == 0) begin
            check("step_underflow", 1, 0);
          end else begin
            cur_e = q.pop_front();
            check("step_latency", lat_cnt, cur_e.lat);
            check("step_out", decode_out(bus.Out), cur_e.value);
            check("step_zero", int'(bus.Zero), int'(cur_e.value == 0));
            check("step_carry", int'(bus.Carry), int'(cur_e.carry));
          end
        end
      end else begin
        check("idle_carry", int'(bus.Carry), 0);
      end

      if (bus.Ready && !busy) begin
        if (bus.Set) pend_set = 1'b1;
        else if (bus.Request) begin
          busy    = 1'b1;
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.Ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.Ready) check("wait_idle_timeout", 0, 1);
  endtask

  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    bus.Set     = 1'b0;
    bus.Request = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst   = 1'b0;
    model = 0;
  endtask

  task automatic do_set(input logic [DIGITS*4-1:0] val, input bit with_req);
    exp_t e;
    wait_idle();
    e.is_set    = 1'b1;
    e.value     = bcd_value(val);
    e.carry     = 1'b0;
    e.lat       = 0;
    bus.Set     = 1'b1;
    bus.In      = val;
    bus.Request = with_req;
    bus.Dec     = 1'($urandom);
    q.push_back(e);
    model = e.value;
    @(posedge clk); #1;
    bus.Set     = 1'b0;
    bus.Request = 1'b0;
  endtask

  task automatic do_step(input bit dn, input bit junk, input int abort_at);
    exp_t e;
    int   n;
    wait_idle();
    e = step_exp(model, dn);
    bus.Request = 1'b1;
    bus.Set     = 1'b0;
    bus.Dec     = dn;
    q.push_back(e);
    model = e.value;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if (abort_at > 0 && n == abort_at && !bus.Ready) begin
        rst         = 1'b1;
        bus.Set     = 1'b0;
        bus.Request = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b0;
        model = 0;
        break;
      end
      if (bus.Ready || n > 500) break;
      if (junk) begin
        bus.Set     = 1'($urandom);
        bus.Request = 1'($urandom);
        bus.Dec     = 1'($urandom);
        bus.In      = (DIGITS*4)'($urandom);
      end else begin
        bus.Set     = 1'b0;
        bus.Request = 1'b0;
      end
    end
    bus.Set     = 1'b0;
    bus.Request = 1'b0;
  endtask

  function automatic logic [DIGITS*4-1:0] rand_bcd();
    logic [DIGITS*4-1:0] v;
    for (int k = 0; k < DIGITS; k++) begin
      case ($urandom_range(0, 3))
        0:       v[4*k +: 4] = 4'd0;
        1:       v[4*k +: 4] = 4'd9;
        default: v[4*k +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
    return v;
  endfunction

  initial begin
    rst         = 1'b1;
    bus.Set     = 1'b0;
    bus.In      = '0;
    bus.Request = 1'b0;
    bus.Dec     = 1'b0;

    do_reset(2);
    do_step(1'b0, 1'b0, 0);
    do_set(12'h099, 1'b0);
    do_step(1'b0, 1'b0, 0);
    do_set(12'h999, 1'b0);
    do_step(1'b0, 1'b0, 0);
    do_step(1'b1, 1'b0, 0);
    do_step(1'b0, 1'b0, 0);
    do_set(12'h0A5, 1'b0);
    do_step(1'b0, 1'b1, 0);
    do_set(12'h123, 1'b1);
    do_step(1'b0, 1'b0, 0);
    do_set(12'h199, 1'b0);
    do_step(1'b0, 1'b0, 6);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    do_set(rand_bcd(), 1'($urandom));
        9:       do_step(1'($urandom), 1'b1, $urandom_range(1, 10));
        default: do_step(1'($urandom), 1'($urandom), 0);
      endcase
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

endmodule
